// File: rtl/spi_frame_sender_pkg.sv
// Shared constants and FSM state type for the HUB75 host-side SPI sender.
// Panel geometry fixes the default frame length (one word per pixel).
// No logic here; imported by the sender and its phase timer.
package hub75_pkg;

  localparam int WORD_BITS   = 16;
  localparam int FRAME_WORDS = 2048;
  localparam int PANEL_W     = 64;
  localparam int PANEL_H     = 32;
  localparam int IDX_W       = 11;
  localparam int TMR_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_frame_sender_phase_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// Latency: a load of N gives a terminal count N cycles later.
// No backpressure: the owner reloads on every terminal count it acts on.
module spi_phase_timer
  import hub75_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [TMR_W-1:0] r_cnt;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_frame_sender.sv
// Host-side SPI word serialiser (MSB first, spi_clk idles low) with frame word counter.
// Latency: 1 accept cycle + WORD_BITS*2*CLK_DIV + GAP_CYCLES per word.
// word_ready only in IDLE; a word never stalls once accepted. Option macro: SPI_FRAME_SYNC_EN.
module spi_frame_sender #(
  parameter int CLK_DIV     = 2,
  parameter int WORD_BITS   = hub75_pkg::WORD_BITS,
  parameter int FRAME_WORDS = hub75_pkg::FRAME_WORDS,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                 sys_clk,
  input  logic                 n_reset,
`ifdef SPI_FRAME_SYNC_EN
  input  logic                 frame_sync,
`endif
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  output logic [10:0]          word_index,
  output logic                 frame_done,
  output logic                 busy
);
  import hub75_pkg::*;

  localparam int               BC_W   = $clog2(WORD_BITS);
  localparam logic [TMR_W-1:0] DIV_LD = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYCLES - 1);

  spi_state_t           r_state;
  logic [WORD_BITS-2:0] r_shreg;     // bits still to send after the one on spi_mosi
  logic [BC_W-1:0]      r_bit_cnt;
  logic                 r_spi_clk;
  logic                 r_spi_mosi;
  logic                 r_frame_done;
  logic [IDX_W-1:0]     r_word_index;

  logic                 w_tc;
  logic                 w_load;
  logic [TMR_W-1:0]     w_load_val;
  logic                 w_pad;
  logic                 w_start;
  logic [WORD_BITS-1:0] w_start_dat;
  logic                 w_last_word;
  logic                 w_gap_end;

`ifdef SPI_FRAME_SYNC_EN
  logic r_sync_pend;

  // Padding runs while a sync request is pending, including the cycle it arrives.
  assign w_pad = r_sync_pend | (frame_sync & (r_word_index != '0));

  // Hold the sync request until the frame counter wraps.
  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync_pend <= 1'b0;
    end else if (w_gap_end && w_last_word) begin
      r_sync_pend <= 1'b0;
    end else if (frame_sync && (r_word_index != '0)) begin
      r_sync_pend <= 1'b1;
    end
  end
`else
  assign w_pad = 1'b0;
`endif

  assign word_ready  = (r_state == IDLE) & ~w_pad;
  assign w_start     = (r_state == IDLE) & (w_pad | word_valid);
  assign w_start_dat = w_pad ? '0 : word_data;
  assign w_last_word = (r_word_index == IDX_W'(FRAME_WORDS - 1));
  assign w_gap_end   = (r_state == GAP) & w_tc;
  assign w_load      = w_start | ((r_state != IDLE) & w_tc);

  // Next phase length: the gap follows the high phase of the last bit, else a clock phase.
  always_comb begin
    w_load_val = DIV_LD;
    if ((r_state == HIGH) && (r_bit_cnt == '0)) begin
      w_load_val = GAP_LD;
    end
  end

  spi_phase_timer u_timer (
    .i_clk      (sys_clk),
    .i_rst_n    (n_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Word sequencer: spi_clk/spi_mosi are registered alongside the state so they track it exactly.
  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_spi_clk    <= 1'b0;
      r_spi_mosi   <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_index <= '0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shreg    <= w_start_dat[WORD_BITS-2:0];
            r_bit_cnt  <= BC_W'(WORD_BITS - 1);
            r_spi_mosi <= w_start_dat[WORD_BITS-1];
            r_state    <= LOW;
          end
        end
        LOW: begin
          if (w_tc) begin
            r_spi_clk <= 1'b1;
            r_state   <= HIGH;
          end
        end
        HIGH: begin
          if (w_tc) begin
            r_spi_clk <= 1'b0;
            if (r_bit_cnt == '0) begin
              r_spi_mosi <= 1'b0;
              r_state    <= GAP;
            end else begin
              r_spi_mosi <= r_shreg[WORD_BITS-2];
              r_shreg    <= {r_shreg[WORD_BITS-3:0], 1'b0};
              r_bit_cnt  <= r_bit_cnt - 1'b1;
              r_state    <= LOW;
            end
          end
        end
        GAP: begin
          if (w_tc) begin
            r_state <= IDLE;
            if (w_last_word) begin
              r_word_index <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_word_index <= r_word_index + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_clk    = r_spi_clk;
  assign spi_mosi   = r_spi_mosi;
  assign frame_done = r_frame_done;
  assign word_index = r_word_index;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/spi_frame_sender.md
Name: spi_frame_sender

Overview:
- Host-side SPI transmitter that feeds the HUB75 panel controller's SPI receive port.
- Accepts 16-bit pixel words (RGB444 in [15:4], [3:0] ignored by the panel) on a valid/ready stream.
- Serialises each word MSB-first on spi_clk/spi_mosi, with no chip-select.
- Counts words per frame so the receiver's double-buffer flips exactly on frame boundaries.

Parameters:
- CLK_DIV, 2: sys_clk cycles per spi_clk phase (low or high); legal range 1..255.
- WORD_BITS, 16: bits per SPI word.
- FRAME_WORDS, 2048: words per frame (64x32 panel, one word per pixel).
- GAP_CYCLES, 8: sys_clk cycles of idle-low spi_clk after each word; legal range 1..255.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- n_reset  in  1  asynchronous active-low reset.
- word_data  in  16  pixel word to send.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  sender can accept a word this cycle.
- spi_clk  out  1  SPI clock; idles low; receiver samples on the rising edge.
- spi_mosi  out  1  SPI data; changes only while spi_clk is low.
- word_index  out  11  index of the next word to be sent in the current frame.
- frame_done  out  1  one-cycle pulse when the last word of a frame finishes its gap.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, n_reset low):
  - spi_clk=0, spi_mosi=0, word_index=0, frame_done=0, busy=0.
  - State=IDLE; the shift register and counters are cleared.
  - Reset mid-word abandons the word immediately; no partial clocking continues.
- word_ready is combinational and equals (state==IDLE). A transfer occurs on any cycle with word_valid and word_ready both high.
- States:
  - IDLE: on transfer, load shreg<=word_data, bit_cnt<=WORD_BITS-1, spi_mosi<=word_data[15], phase_cnt<=0, then go to LOW.
  - LOW: spi_clk=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: spi_clk=1 for CLK_DIV cycles. At the end of HIGH:
    - if bit_cnt==0, go to GAP;
    - otherwise shift left, drive spi_mosi<=next bit, bit_cnt-1, and go to LOW.
  - GAP: spi_clk=0, spi_mosi=0 for GAP_CYCLES cycles. At the end of GAP:
    - update word_index (see Frame counter below);
    - return to IDLE.
- Timing:
  - spi_clk period is 2*CLK_DIV sys_clk cycles.
  - Word cost: 1 accept cycle + 16*2*CLK_DIV + GAP_CYCLES. With the defaults this is 1+64+8 = 73 cycles.
  - spi_mosi is stable for the whole high phase plus at least CLK_DIV cycles before the rising edge.
- Frame counter:
  - word_index increments at the end of GAP.
  - When word_index==FRAME_WORDS-1 it wraps to 0 and frame_done pulses high on that same cycle.
- word_valid deasserting while busy has no effect; the sender never stalls mid-word.
- No SPI output activity occurs in IDLE.

Optional Feature:
- Macro: SPI_FRAME_SYNC_EN.
- With the macro defined:
  - Extra input port frame_sync (1 bit).
  - If frame_sync is high in IDLE and word_index!=0, word_ready is forced to 0.
  - The sender then transmits 0x0000 pad words, with normal timing, until word_index wraps to 0. frame_done pulses as usual.
  - frame_sync is latched, so a one-cycle pulse is enough.
  - frame_sync with word_index==0 does nothing.
  - This realigns the receiver's double-buffer after upstream underflow.
- Without the macro: the frame_sync port and the padding logic do not exist.

Decomposition:
- Shared package hub75_pkg holds:
  - constants WORD_BITS=16, FRAME_WORDS=2048, PANEL_W=64, PANEL_H=32;
  - the state enum {IDLE, LOW, HIGH, GAP}.
- One sub-module, spi_phase_timer: a loadable down-counter with a terminal-count pulse, used for the CLK_DIV and GAP_CYCLES durations.

Test Plan:
- Single word 0xF0A5, CLK_DIV=2: 16 spi_clk rising edges; bits sampled at the edges read 1111_0000_1010_0101; each high phase lasts 2 cycles; word_ready is low for 72 cycles after the accept.
- Back-to-back words 0x1234 then 0xABCD with valid held high: the second accept occurs on the cycle GAP ends; there is exactly GAP_CYCLES=8 of idle-low spi_clk between the words; both words are decoded correctly.
- 2048 words, FRAME_WORDS=2048: frame_done pulses once, on the end-GAP cycle of word 2047; word_index reads 0 afterwards; a second frame pulses again after another 2048 words.
- n_reset asserted after the 5th rising edge of a word: spi_clk and spi_mosi go 0 asynchronously; word_index returns to 0; the next accepted word is sent from bit 15.
- word_valid low for 100 cycles: spi_clk stays 0, busy stays 0, word_ready stays 1.
- SPI_FRAME_SYNC_EN: send 10 words, pulse frame_sync → 2038 0x0000 words are sent; frame_done pulses; then word_ready returns to 1.
